// File: rtl/shape_raster.sv
// Rasterises rectangle / Bresenham line commands into a valid/ready pixel stream.
// Optional macro RASTER_RECT_FILL_EN switches rectangles from outline to filled box.
module shape_raster #(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] point_a_x,
  input  logic [COORD_W-1:0] point_a_y,
  input  logic [COORD_W-1:0] point_b_x,
  input  logic [COORD_W-1:0] point_b_y,
  input  logic               shape_trigger,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               busy,
  output logic               done
);

`ifdef RASTER_RECT_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, EMIT, DONE} state_t;
  typedef enum logic [1:0] {MODE_NOP0, MODE_RECT, MODE_LINE, MODE_NOP3} mode_t;

  state_t state, state_nxt;

  logic                      is_line;
  logic [COORD_W-1:0]        a_x, a_y, b_x, b_y;
  logic [COORD_W-1:0]        x0, x1, y0, y1;
  logic [COORD_W:0]          dx;
  logic signed [COORD_W+1:0] dy, err;
  logic                      x_neg, y_neg;

  logic start, last;
  assign start = shape_trigger && (mode == MODE_RECT || mode == MODE_LINE);
  assign last  = is_line ? (pix_x == b_x && pix_y == b_y) : (pix_x == x1 && pix_y == y1);

  // Setup terms derived from the latched command
  logic [COORD_W:0]          dx_c, dy_mag;
  logic signed [COORD_W+1:0] dy_c, err_c;
  logic [COORD_W-1:0]        min_x, max_x, min_y, max_y;
  always_comb begin
    min_x  = (point_le(a_x, b_x)) ? a_x : b_x;
    max_x  = (point_le(a_x, b_x)) ? b_x : a_x;
    min_y  = (point_le(a_y, b_y)) ? a_y : b_y;
    max_y  = (point_le(a_y, b_y)) ? b_y : a_y;
    dx_c   = {1'b0, max_x} - {1'b0, min_x};
    dy_mag = {1'b0, max_y} - {1'b0, min_y};
    dy_c   = -$signed({1'b0, dy_mag});
    err_c  = $signed({1'b0, dx_c}) + dy_c;
  end

  function automatic logic point_le(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] q);
    return p <= q;
  endfunction

  // Next-pixel computation for both shape kinds
  logic signed [COORD_W+2:0] e2;
  logic                      step_x, step_y;
  logic signed [COORD_W+1:0] err_nxt;
  logic                      edge_row;
  logic [COORD_W-1:0]        nx, ny;
  always_comb begin
    e2       = $signed({err, 1'b0});
    step_x   = e2 >= $signed({dy[COORD_W+1], dy});
    step_y   = e2 <= $signed({2'b00, dx});
    err_nxt  = err + (step_x ? dy : '0) + (step_y ? $signed({1'b0, dx}) : '0);
    edge_row = FILL || pix_y == y0 || pix_y == y1;
    nx       = pix_x;
    ny       = pix_y;
    if (is_line) begin
      if (step_x) nx = x_neg ? pix_x - 1'b1 : pix_x + 1'b1;
      if (step_y) ny = y_neg ? pix_y - 1'b1 : pix_y + 1'b1;
    end else if (pix_x == x1) begin
      nx = x0;
      ny = pix_y + 1'b1;
    end else if (edge_row) begin
      nx = pix_x + 1'b1;
    end else begin
      // interior outline row: jump straight from left edge to right edge
      nx = x1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = EMIT;
      EMIT:    if (pix_ready && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_valid = (state == EMIT);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_line <= 1'b0;
      a_x <= '0; a_y <= '0; b_x <= '0; b_y <= '0;
      x0  <= '0; x1  <= '0; y0  <= '0; y1  <= '0;
      dx  <= '0; dy  <= '0; err <= '0;
      x_neg <= 1'b0; y_neg <= 1'b0;
      pix_x <= '0; pix_y <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          is_line <= (mode == MODE_LINE);
          a_x <= point_a_x; a_y <= point_a_y;
          b_x <= point_b_x; b_y <= point_b_y;
        end
        SETUP: begin
          x0 <= min_x; x1 <= max_x; y0 <= min_y; y1 <= max_y;
          dx <= dx_c; dy <= dy_c; err <= err_c;
          x_neg <= b_x < a_x;
          y_neg <= b_y < a_y;
          pix_x <= is_line ? a_x : min_x;
          pix_y <= is_line ? a_y : min_y;
        end
        EMIT: if (pix_ready && !last) begin
          pix_x <= nx;
          pix_y <= ny;
          err   <= err_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_raster.sv
// Randomised self-checking bench for shape_raster against a queue-based pixel model.
// Honours RASTER_RECT_FILL_EN the same way as the design.
module tb_shape_raster;
  localparam int COORD_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         mode = '0;
  logic [COORD_W-1:0] point_a_x = '0, point_a_y = '0, point_b_x = '0, point_b_y = '0;
  logic               shape_trigger = 1'b0;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic               pix_valid, pix_ready = 1'b0;
  logic               busy, done;

  int tests  = 0;
  int errors = 0;

  typedef struct { int x; int y; } pix_t;

  shape_raster #(.COORD_W(COORD_W)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .point_a_x(point_a_x), .point_a_y(point_a_y),
    .point_b_x(point_b_x), .point_b_y(point_b_y),
    .shape_trigger(shape_trigger),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference pixel list straight from the shape definitions
  task automatic build_expected(input int m, ax, ay, bx, by, output pix_t q[$]);
    bit fill;
    q.delete();
`ifdef RASTER_RECT_FILL_EN
    fill = 1'b1;
`else
    fill = 1'b0;
`endif
    if (m == 1) begin
      int lx = (ax < bx) ? ax : bx, hx = (ax < bx) ? bx : ax;
      int ly = (ay < by) ? ay : by, hy = (ay < by) ? by : ay;
      for (int y = ly; y <= hy; y++)
        for (int x = lx; x <= hx; x++)
          if (fill || y == ly || y == hy || x == lx || x == hx) q.push_back('{x, y});
    end else begin
      int x = ax, y = ay;
      int dx = (bx > ax) ? bx - ax : ax - bx;
      int dy = (by > ay) ? ay - by : by - ay;
      int sx = (bx >= ax) ? 1 : -1, sy = (by >= ay) ? 1 : -1;
      int err = dx + dy, e2;
      forever begin
        q.push_back('{x, y});
        if (x == bx && y == by) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready dropped for 3 cycles after 2 pixels
  task automatic run_shape(input int m, ax, ay, bx, by, input int rmode,
                           input bit intrude, input bit chk_lat);
    pix_t exp_q[$];
    int   n = 0, drop = 0, limit, cyc;
    bit   stalled = 0, sent = 0, r, finished = 0;
    int   hx = 0, hy = 0;
    build_expected(m, ax, ay, bx, by, exp_q);
    limit = 8 * exp_q.size() + 100;
    @(negedge clk);
    mode = 2'(m);
    point_a_x = 8'(ax); point_a_y = 8'(ay); point_b_x = 8'(bx); point_b_y = 8'(by);
    shape_trigger = 1'b1;
    pix_ready = 1'b0;
    @(negedge clk);
    shape_trigger = 1'b0;
    if (chk_lat) begin
      check("setup_valid", pix_valid, 0);
      check("setup_busy", busy, 1);
    end
    for (cyc = 0; cyc < limit; cyc++) begin
      @(negedge clk);
      shape_trigger = 1'b0;
      if (cyc == 0 && chk_lat) check("first_valid", pix_valid, 1);
      check("done_early", done, 0);
      if (stalled) begin
        check("hold_valid", pix_valid, 1);
        check("hold_x", pix_x, hx);
        check("hold_y", pix_y, hy);
      end
      if (intrude && !sent && n == 1) begin
        sent = 1;
        mode = 2'd1;
        point_a_x = 8'd200; point_a_y = 8'd200; point_b_x = 8'd210; point_b_y = 8'd205;
        shape_trigger = 1'b1;
      end
      case (rmode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          r = !(n >= 2 && drop < 3);
          if (!r) drop++;
        end
      endcase
      pix_ready = r;
      stalled = 0;
      if (pix_valid) begin
        if (r) begin
          check("pix_x", pix_x, exp_q[n].x);
          check("pix_y", pix_y, exp_q[n].y);
          n++;
          if (n == exp_q.size()) begin finished = 1; break; end
        end else begin
          stalled = 1; hx = int'(pix_x); hy = int'(pix_y);
        end
      end
    end
    check("finished_in_budget", finished, 1);
    check("pixel_count", n, exp_q.size());
    @(negedge clk);
    pix_ready = 1'b0;
    check("done_pulse", done, 1);
    check("valid_after_last", pix_valid, 0);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("busy_cleared", busy, 0);
  endtask

  initial begin
    int ax, ay, bx, by, m;
    #2;
    check("rst_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", pix_x, 0);
    check("rst_y", pix_y, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_shape(2, 0, 0, 3, 0, 0, 0, 1);
    run_shape(2, 5, 5, 2, 7, 0, 0, 1);
    run_shape(1, 4, 3, 1, 1, 0, 0, 1);
    run_shape(1, 7, 7, 7, 7, 0, 0, 0);
    run_shape(2, 9, 4, 9, 4, 0, 0, 0);
    run_shape(2, 10, 20, 30, 2, 2, 0, 0);
    run_shape(1, 0, 0, 255, 2, 1, 0, 0);
    run_shape(2, 255, 0, 0, 255, 1, 0, 0);
    run_shape(2, 3, 3, 12, 8, 0, 1, 0);

    // Ignored no-op triggers
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mode = (k == 0) ? 2'd0 : 2'd3;
      point_a_x = 8'd1; point_a_y = 8'd1; point_b_x = 8'd5; point_b_y = 8'd5;
      shape_trigger = 1'b1;
      @(negedge clk);
      shape_trigger = 1'b0;
      for (int c = 0; c < 4; c++) begin
        check("nop_busy", busy, 0);
        check("nop_valid", pix_valid, 0);
        check("nop_done", done, 0);
        @(negedge clk);
      end
    end

    // Reset in the middle of a stream
    @(negedge clk);
    mode = 2'd2;
    point_a_x = 8'd10; point_a_y = 8'd10; point_b_x = 8'd40; point_b_y = 8'd20;
    shape_trigger = 1'b1;
    @(negedge clk);
    shape_trigger = 1'b0;
    pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_rst_valid", pix_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", pix_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_x", pix_x, 0);
    @(negedge clk);
    rst = 1'b0;
    pix_ready = 1'b0;
    @(negedge clk);
    check("post_rst_valid", pix_valid, 0);
    run_shape(2, 10, 10, 40, 20, 1, 0, 1);

    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(1, 2);
      ax = $urandom_range(0, 255);
      ay = $urandom_range(0, 255);
      if (m == 1) begin
        bx = ax + int'($urandom_range(0, 30)) - 15;
        by = ay + int'($urandom_range(0, 30)) - 15;
        if (bx < 0) bx = 0;
        if (bx > 255) bx = 255;
        if (by < 0) by = 0;
        if (by > 255) by = 255;
      end else begin
        bx = $urandom_range(0, 255);
        by = $urandom_range(0, 255);
      end
      if ($urandom_range(0, 7) == 0) begin bx = ax; by = ay; end
      run_shape(m, ax, ay, bx, by, $urandom_range(0, 2), ($urandom_range(0, 4) == 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
